data_stream_chk: RTL and testbench
==================================

# data_stream_chk

Serial pattern checker; the receive end of the team's fixed-pattern bit-stream generator. It takes a single-bit stream in which each bit is held `HOLD_CYCLES` clocks, sent index 0 first. It recovers bit timing from data transitions, aligns to `BIT_STREAM`, and then checks every received bit against the expected pattern. It reports lock status, per-bit errors, a saturating error count and clean-frame pulses; it is used for loopback and link bring-up tests.

## Interface
Parameters:
- `STREAM_LEN`, 8: pattern length in bits; must be ≥ 2.
- `BIT_STREAM`, 8'b10101010: expected pattern `[STREAM_LEN-1:0]`; bit 0 is transmitted first.
- `HOLD_CYCLES`, 10: clocks per bit; must be ≥ 3.
- `LOOP`, 1: 1 = continuous periodic stream; 0 = one-shot frames, each of which is re-acquired.
- `LOSS_ERRS`, 4: consecutive bit errors that drop lock; must be ≥ 1.
- `ERR_W`, 16: width of `err_count`.

Ports:
- `clk`  in  1  sole clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-low reset (asserted when 0).
- `data_in`  in  1  serial stream, synchronous to `clk`.
- `clr_in`  in  1  synchronous clear of `err_count`.
- `locked`  out  1  high while aligned to the pattern.
- `bit_err`  out  1  one-cycle pulse on each mismatched bit while locked.
- `err_count`  out  ERR_W  total mismatches; saturates at all-ones.
- `frame_ok`  out  1  one-cycle pulse after a full `STREAM_LEN`-bit frame with zero errors.

## Operation
- Reset (`reset`=0 at an edge) sets: state SEARCH, `locked`=0, `bit_err`=0, `frame_ok`=0, `err_count`=0, shift register `sreg`=0, phase counter `ph`=0, bit index `idx`=0, consecutive-error counter=0, `data_d`=0. Reset applies mid-frame with no residue.
- Transition detection: `data_d` is `data_in` registered. A transition is `data_in != data_d`; the cycle in which it is seen is bit cycle 0.
- Phase counter update, per cycle:
  - on a transition, `ph <= 1`;
  - otherwise, `ph <= (ph == HOLD_CYCLES-1) ? 0 : ph+1`.
  - With no transitions, `ph` free-runs, so runs of equal bits keep their timing.
- Sample strobe: asserted in a cycle with `ph == HOLD_CYCLES/2` (floor) and no transition. The sampled bit is `data_in`.
- On each strobe, `sreg <= {data_in, sreg[STREAM_LEN-1:1]}`; the oldest bit ends up in `sreg[0]`.
- SEARCH state, on a strobe:
  - if the shifted value equals `BIT_STREAM`: go to LOCKED, `idx <= 0`, clear the consecutive-error and frame-error flags;
  - the lock event itself does not pulse `frame_ok`.
- LOCKED state, on a strobe: compare the sampled bit with `BIT_STREAM[idx]`.
  - Mismatch: `bit_err` pulses; `err_count` increments (holds at 2^ERR_W−1); consecutive errors +1; the frame is marked errored.
  - Match: consecutive errors reset to 0.
  - `idx == STREAM_LEN-1`: `idx <= 0`; `frame_ok` pulses if the frame had no error; the frame flag clears. If `LOOP`=0, also return to SEARCH (`locked` falls).
  - Otherwise `idx <= idx+1`.
  - If consecutive errors reach `LOSS_ERRS`: go to SEARCH, `locked` falls. `sreg` is kept; re-alignment is evaluated from the next strobe.
  - If loss and end of frame happen on the same strobe: the `frame_ok` rule still applies (the frame is errored, so no pulse); the state is SEARCH.
- `clr_in`=1 zeroes `err_count`. If it coincides with an increment, the clear wins (result 0).
- Periodic patterns (e.g. the default) can align on any self-matching rotation. This is accepted: every such alignment checks with zero errors.

## Timing
- All outputs are registered. For a strobe in cycle S, `locked` changes, and `bit_err`, `frame_ok` and the `err_count` update appear, in cycle S+1.
- `bit_err` and `frame_ok` are high for exactly one cycle.
- Sample point: bit cycle `HOLD_CYCLES/2` after the bit start. With defaults that is cycle 5 of a 10-cycle bit, so the error latency from bit start is 6 cycles.
- Minimum lock time from a clean start: `STREAM_LEN` bits, i.e. the strobe of bit `STREAM_LEN-1` plus 1 cycle.

## Test plan
- Defaults, the bench drives `BIT_STREAM` looped with 10-cycle bits from reset release. Required: `locked`=1 no later than 1 cycle after the 8th strobe; afterwards `frame_ok` pulses every 80 cycles; `bit_err` stays 0; `err_count`=0.
- `BIT_STREAM`=8'b11100100, locked stream, one bit inverted. Required: exactly one `bit_err` pulse 6 cycles after that bit starts; `err_count`=1; no `frame_ok` for that frame; `locked` stays 1.
- Five consecutive bits inverted with `LOSS_ERRS`=4. Required: `err_count`=4 and `locked`=0 one cycle after the 4th errored strobe; re-lock after the next full clean pattern.
- `LOOP`=0, one-shot frame followed by a held last bit, restarted 200 cycles later. Required: one `frame_ok`; `locked` falls after bit 7 and rises again on the second frame.
- `ERR_W`=2 with a continuous error stream. Required: `err_count` saturates at 3. Then `clr_in`=1 together with an error strobe gives `err_count`=0.
- Assert `reset`=0 mid-frame for 1 cycle. Required: all outputs are 0 the next cycle; re-lock is clean.

Source files
------------

// File: rtl/data_stream_chk.sv
`timescale 1ns/1ps
// data_stream_chk
//   Receive-side checker for the fixed-pattern serial bit-stream generator.
//   Recovers bit timing from data edges, aligns to BIT_STREAM and then checks
//   every received bit against the pattern, reporting lock, per-bit errors,
//   a saturating error count and clean-frame pulses.
//
// Ports
//   clk        sole clock, rising edge
//   reset      synchronous reset, active low
//   data_in    serial stream, each bit held HOLD_CYCLES clocks, bit 0 first
//   clr_in     synchronous clear of err_count (wins over an increment)
//   locked     high while aligned to the pattern
//   bit_err    one-cycle pulse per mismatched bit while locked
//   err_count  total mismatches, saturating at all-ones
//   frame_ok   one-cycle pulse after a full frame with no errors
//
// States
//   SEARCH | shifting samples in, waiting for the last STREAM_LEN bits to equal BIT_STREAM
//   LOCKED | aligned; each sample is checked against BIT_STREAM[idx]
module data_stream_chk #(
  parameter int                    STREAM_LEN  = 8,
  parameter logic [STREAM_LEN-1:0] BIT_STREAM  = 8'b10101010,
  parameter int                    HOLD_CYCLES = 10,
  parameter int                    LOOP        = 1,
  parameter int                    LOSS_ERRS   = 4,
  parameter int                    ERR_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data_in,
  input  logic             clr_in,
  output logic             locked,
  output logic             bit_err,
  output logic [ERR_W-1:0] err_count,
  output logic             frame_ok
);

  localparam int PH_W  = $clog2(HOLD_CYCLES);
  localparam int IDX_W = (STREAM_LEN > 2) ? $clog2(STREAM_LEN) : 1;
  localparam int CE_W  = $clog2(LOSS_ERRS + 1);

  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(HOLD_CYCLES - 1);
  localparam logic [PH_W-1:0]  PH_MID   = PH_W'(HOLD_CYCLES / 2);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(STREAM_LEN - 1);
  localparam logic [CE_W-1:0]  CE_LOSS  = CE_W'(LOSS_ERRS);

  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

  state_t                state, state_nx;
  // Only the upper STREAM_LEN-1 sample bits are stored: the oldest bit of the
  // shift register is consumed by the alignment compare and never needed again.
  logic [STREAM_LEN-2:0] hist, hist_nx;
  logic [STREAM_LEN-1:0] sreg_shift;
  logic [PH_W-1:0]       ph, ph_nx;
  logic [IDX_W-1:0]      idx, idx_nx;
  logic [CE_W-1:0]       cerr, cerr_nx;
  logic                  ferr, ferr_nx;
  logic                  data_d;
  logic                  bit_err_nx, frame_ok_nx;
  logic [ERR_W-1:0]      cnt_nx;
  logic                  trans, strobe, bit_mis;

  assign trans      = (data_in != data_d);
  assign strobe     = !trans && (ph == PH_MID);
  assign sreg_shift = {data_in, hist};
  assign bit_mis    = (data_in != BIT_STREAM[idx]);
  assign locked     = (state == LOCKED);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= SEARCH;
      hist      <= '0;
      ph        <= '0;
      idx       <= '0;
      cerr      <= '0;
      ferr      <= 1'b0;
      data_d    <= 1'b0;
      bit_err   <= 1'b0;
      frame_ok  <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_nx;
      hist      <= hist_nx;
      ph        <= ph_nx;
      idx       <= idx_nx;
      cerr      <= cerr_nx;
      ferr      <= ferr_nx;
      data_d    <= data_in;
      bit_err   <= bit_err_nx;
      frame_ok  <= frame_ok_nx;
      err_count <= cnt_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    hist_nx     = hist;
    idx_nx      = idx;
    cerr_nx     = cerr;
    ferr_nx     = ferr;
    bit_err_nx  = 1'b0;
    frame_ok_nx = 1'b0;
    cnt_nx      = err_count;

    // A transition marks bit cycle 0, so the next cycle is bit cycle 1.
    // Without transitions the counter free-runs to keep timing over equal bits.
    if (trans) begin
      ph_nx = PH_W'(1);
    end else if (ph == PH_LAST) begin
      ph_nx = '0;
    end else begin
      ph_nx = ph + PH_W'(1);
    end

    if (strobe) begin
      hist_nx = sreg_shift[STREAM_LEN-1:1];
      case (state)
        SEARCH: begin
          if (sreg_shift == BIT_STREAM) begin
            state_nx = LOCKED;
            idx_nx   = '0;
            cerr_nx  = '0;
            ferr_nx  = 1'b0;
          end
        end
        LOCKED: begin
          if (bit_mis) begin
            bit_err_nx = 1'b1;
            if (err_count != {ERR_W{1'b1}}) begin
              cnt_nx = err_count + ERR_W'(1);
            end
            // cerr cannot pass LOSS_ERRS: lock drops when it gets there
            cerr_nx = cerr + CE_W'(1);
            ferr_nx = 1'b1;
          end else begin
            cerr_nx = '0;
          end

          if (idx == IDX_LAST) begin
            idx_nx      = '0;
            frame_ok_nx = !(ferr || bit_mis);
            ferr_nx     = 1'b0;
            if (LOOP == 0) begin
              state_nx = SEARCH;
            end
          end else begin
            idx_nx = idx + IDX_W'(1);
          end

          // The shift register is kept so re-alignment starts on the next strobe.
          if (cerr_nx >= CE_LOSS) begin
            state_nx = SEARCH;
          end
        end
        default: state_nx = SEARCH;
      endcase
    end

    if (clr_in) begin
      cnt_nx = '0;
    end
  end

endmodule

// File: tb/tb_data_stream_chk.sv
`timescale 1ns/1ps
module tb_data_stream_chk;

  localparam logic [7:0] P0 = 8'b10101010;
  localparam logic [7:0] P1 = 8'b11100100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, data, clr;
  logic [3:0] lk, be, fo;
  logic [15:0] ec0, ec1, ec2;
  logic [1:0] ec3;

  data_stream_chk u_def (
    .clk(clk), .reset(reset), .data_in(data), .clr_in(clr),
    .locked(lk[0]), .bit_err(be[0]), .err_count(ec0), .frame_ok(fo[0]));

  data_stream_chk #(.BIT_STREAM(P1)) u_pat (
    .clk(clk), .reset(reset), .data_in(data), .clr_in(clr),
    .locked(lk[1]), .bit_err(be[1]), .err_count(ec1), .frame_ok(fo[1]));

  data_stream_chk #(.LOOP(0)) u_one (
    .clk(clk), .reset(reset), .data_in(data), .clr_in(clr),
    .locked(lk[2]), .bit_err(be[2]), .err_count(ec2), .frame_ok(fo[2]));

  data_stream_chk #(.BIT_STREAM(P1), .ERR_W(2)) u_sat (
    .clk(clk), .reset(reset), .data_in(data), .clr_in(clr),
    .locked(lk[3]), .bit_err(be[3]), .err_count(ec3), .frame_ok(fo[3]));

  int sel;
  logic o_lk, o_be, o_fo;
  int o_ec;

  always_comb begin
    o_lk = lk[sel];
    o_be = be[sel];
    o_fo = fo[sel];
    o_ec = 0;
    case (sel)
      0: o_ec = int'(ec0);
      1: o_ec = int'(ec1);
      2: o_ec = int'(ec2);
      default: o_ec = int'(ec3);
    endcase
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // pulse monitor and frame_ok spacing
  int n_be, n_fo, cyc, last_fo;
  bit gap_en;
  initial begin
    cyc = 0; n_be = 0; n_fo = 0; last_fo = -1; gap_en = 0;
  end
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (o_be) n_be++;
    if (o_fo) begin
      n_fo++;
      if (gap_en) begin
        if (last_fo >= 0) chk("frame_ok_gap", cyc - last_fo, 80);
        last_fo = cyc;
      end
    end
  end

  // bit-level reference model and scoreboard
  typedef struct {
    logic be;
    logic fo;
    logic lk;
    int   ec;
  } exp_t;
  exp_t sb[$];

  logic [7:0] m_pat, m_sreg;
  bit   m_loop, m_lock, m_ferr;
  int   m_errmax, m_idx, m_cerr, m_cnt;
  int   exp_be, exp_fo;

  task automatic model_reset(input logic [7:0] pat, input bit loop, input int errmax);
    m_pat = pat; m_loop = loop; m_errmax = errmax;
    m_sreg = '0; m_lock = 0; m_ferr = 0; m_idx = 0; m_cerr = 0; m_cnt = 0;
    exp_be = 0; exp_fo = 0; n_be = 0; n_fo = 0;
    sb.delete();
  endtask

  task automatic model_step(input logic b, input logic c);
    exp_t e;
    logic [7:0] sh;
    logic mis;
    e.be = 0; e.fo = 0;
    sh = {b, m_sreg[7:1]};
    if (!m_lock) begin
      if (sh == m_pat) begin
        m_lock = 1; m_idx = 0; m_cerr = 0; m_ferr = 0;
      end
    end else begin
      mis = (b != m_pat[m_idx]);
      if (mis) begin
        e.be = 1;
        if (m_cnt < m_errmax) m_cnt++;
        m_cerr++;
        m_ferr = 1;
      end else begin
        m_cerr = 0;
      end
      if (m_idx == 7) begin
        e.fo = !m_ferr;
        m_ferr = 0;
        m_idx = 0;
        if (!m_loop) m_lock = 0;
      end else begin
        m_idx++;
      end
      if (m_cerr >= 4) m_lock = 0;
    end
    if (c) m_cnt = 0;
    m_sreg = sh;
    e.lk = m_lock;
    e.ec = m_cnt;
    if (e.be) exp_be++;
    if (e.fo) exp_fo++;
    sb.push_back(e);
  endtask

  // Called 1 time unit after a rising edge; returns at the same phase one bit later.
  task automatic send_bit(input logic b, input logic do_clr);
    exp_t e;
    model_step(b, do_clr);
    data = b;
    for (int c = 0; c < 10; c++) begin
      if (c == 5 && do_clr) clr = 1'b1;
      if (c == 6) clr = 1'b0;
      @(negedge clk);
      if (c == 6) begin
        e = sb.pop_front();
        chk("bit_err", int'(o_be), int'(e.be));
        chk("frame_ok", int'(o_fo), int'(e.fo));
        chk("locked", int'(o_lk), int'(e.lk));
        chk("err_count", o_ec, e.ec);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] v, input logic [7:0] inv);
    for (int i = 0; i < 8; i++) send_bit(v[i] ^ inv[i], 1'b0);
  endtask

  task automatic restart(input int s, input logic [7:0] pat, input bit loop, input int errmax);
    reset = 1'b0;
    @(posedge clk);
    #1;
    sel = s;
    model_reset(pat, loop, errmax);
    reset = 1'b1;
  endtask

  task automatic count_checks(input string tag);
    chk({tag, "_n_bit_err"}, n_be, exp_be);
    chk({tag, "_n_frame_ok"}, n_fo, exp_fo);
  endtask

  initial begin
    reset = 1'b0; data = 1'b0; clr = 1'b0; sel = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 4; s++) begin
      sel = s;
      #1;
      chk("rst_locked", int'(o_lk), 0);
      chk("rst_bit_err", int'(o_be), 0);
      chk("rst_frame_ok", int'(o_fo), 0);
      chk("rst_err_count", o_ec, 0);
    end
    @(posedge clk);
    #1;

    // clean looped default pattern from reset release
    sel = 0;
    model_reset(P0, 1, 65535);
    reset = 1'b1;
    gap_en = 1;
    send_frame(P0, 8'h00);
    chk("t1_lock_by_8th", int'(o_lk), 1);
    repeat (3) send_frame(P0, 8'h00);
    gap_en = 0;
    chk("t1_n_frame_ok", n_fo, 3);
    chk("t1_n_bit_err", n_be, 0);
    chk("t1_err_count", o_ec, 0);
    count_checks("t1");

    // five consecutive inverted bits: loss after the fourth, then re-lock
    model_reset(P0, 1, 65535);
    m_lock = 1; m_sreg = P0;
    for (int i = 0; i < 4; i++) send_bit(P0[i] ^ 1'b1, 1'b0);
    chk("t3_err_count_at_loss", o_ec, 4);
    chk("t3_locked_at_loss", int'(o_lk), 0);
    send_bit(P0[4] ^ 1'b1, 1'b0);
    for (int i = 5; i < 8; i++) send_bit(P0[i], 1'b0);
    send_frame(P0, 8'h00);
    send_frame(P0, 8'h00);
    chk("t3_relocked", int'(o_lk), 1);
    chk("t3_err_count", o_ec, 4);
    chk("t3_n_bit_err", n_be, 4);

    // reset pulse in the middle of a frame
    for (int i = 0; i < 3; i++) send_bit(P0[i], 1'b0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("t6_locked", int'(o_lk), 0);
    chk("t6_bit_err", int'(o_be), 0);
    chk("t6_frame_ok", int'(o_fo), 0);
    chk("t6_err_count", o_ec, 0);
    model_reset(P0, 1, 65535);
    reset = 1'b1;
    repeat (3) send_frame(P0, 8'h00);
    chk("t6_relocked", int'(o_lk), 1);
    chk("t6_n_frame_ok", n_fo, 2);
    count_checks("t6");

    // single inverted bit with a non-periodic pattern
    restart(1, P1, 1, 65535);
    send_frame(P1, 8'h00);
    send_frame(P1, 8'h00);
    send_frame(P1, 8'h08);
    send_frame(P1, 8'h00);
    chk("t2_n_bit_err", n_be, 1);
    chk("t2_err_count", o_ec, 1);
    chk("t2_locked", int'(o_lk), 1);
    chk("t2_n_frame_ok", n_fo, 2);
    count_checks("t2");

    // one-shot frames, held line, restart
    restart(2, P0, 0, 65535);
    send_frame(P0, 8'h00);
    send_frame(P0, 8'h00);
    chk("t4_n_frame_ok_1", n_fo, 1);
    chk("t4_unlocked_1", int'(o_lk), 0);
    repeat (20) send_bit(P0[7], 1'b0);
    chk("t4_idle_unlocked", int'(o_lk), 0);
    send_frame(P0, 8'h00);
    chk("t4_relocked", int'(o_lk), 1);
    send_frame(P0, 8'h00);
    chk("t4_n_frame_ok_2", n_fo, 2);
    chk("t4_unlocked_2", int'(o_lk), 0);
    count_checks("t4");

    // 2-bit counter saturation and clear against an error strobe
    restart(3, P1, 1, 3);
    send_frame(P1, 8'h00);
    send_frame(P1, 8'h0F);
    chk("t5_saturated", o_ec, 3);
    chk("t5_unlocked", int'(o_lk), 0);
    send_frame(P1, 8'h00);
    chk("t5_relocked", int'(o_lk), 1);
    send_bit(P1[0] ^ 1'b1, 1'b1);
    chk("t5_clr_wins", o_ec, 0);
    send_bit(P1[1] ^ 1'b1, 1'b0);
    chk("t5_count_after_clr", o_ec, 1);
    for (int i = 2; i < 8; i++) send_bit(P1[i], 1'b0);
    count_checks("t5");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
